// File: rtl/exe_stage_mc.sv
`default_nettype none
// ============================================================================
// exe_stage_mc : ARM execute stage with built-in EXE/MEM register, N-source
//                forwarding and an iterative radix-2^MUL_BITS multiplier.
// Rev 1.0
// ============================================================================
module exe_stage_mc #(
   parameter int NUM_FWD_SRC = 2,
   parameter int MUL_BITS    = 1,
   localparam int FWD_SEL_W  = $clog2(NUM_FWD_SRC + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      stall_in,
   input  logic                      flush,
   input  logic                      valid_in,
   input  logic                      wb_en_in,
   input  logic                      mem_r_en_in,
   input  logic                      mem_w_en_in,
   input  logic                      status_w_en_in,
   input  logic                      branch_taken_in,
   input  logic                      immd,
   input  logic [3:0]                exe_cmd,
   input  logic [31:0]               pc_in,
   input  logic [31:0]               val_Rn,
   input  logic [31:0]               val_Rm,
   input  logic [3:0]                dest_in,
   input  logic [23:0]               signed_immd_24,
   input  logic [11:0]               shift_operand,
   input  logic [3:0]                status_reg_in,
   input  logic [FWD_SEL_W-1:0]      fwd_sel_src1,
   input  logic [FWD_SEL_W-1:0]      fwd_sel_src2,
   input  logic [32*NUM_FWD_SRC-1:0] fwd_values,
   output logic                      busy,
   output logic                      valid_out,
   output logic                      wb_en_out,
   output logic                      mem_r_en_out,
   output logic                      mem_w_en_out,
   output logic                      status_w_en_out,
   output logic                      branch_taken_out,
   output logic [3:0]                dest_out,
   output logic [31:0]               alu_res,
   output logic [31:0]               val_Rm_out,
   output logic [31:0]               branch_address,
   output logic [3:0]                status_out
);
   localparam int STEPS = 32 / MUL_BITS;
   localparam int CNT_W = $clog2(STEPS);

   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_MVN = 4'b1001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;
   localparam logic [3:0] CMD_MUL = 4'b1010;

   typedef enum logic [0:0] {IDLE = 1'b0, MUL_RUN = 1'b1} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      acc;
   logic [31:0]      mul_rn;
   logic [31:0]      mul_rm;
   logic [3:0]       mul_dest;
   logic             mul_wb;
   logic             mul_sw;

   logic [31:0]         src1;
   logic [31:0]         src2;
   logic [31:0]         val2;
   logic [31:0]         alu_out;
   logic [31:0]         br_addr;
   logic [32:0]         sum;
   logic                c_f;
   logic                v_f;
   logic [4:0]          shamt;
   logic [MUL_BITS-1:0] digit;
   logic [31:0]         partial;
   logic [31:0]         acc_next;
   logic                is_mul;
   logic                last;
   logic                unused_nz;

   function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] r);
      return (x >> r) | (x << (6'd32 - {1'b0, r}));
   endfunction

   assign is_mul    = (exe_cmd == CMD_MUL);
   assign last      = (cnt == CNT_W'(STEPS - 1));
   assign br_addr   = pc_in + {{6{signed_immd_24[23]}}, signed_immd_24, 2'b00};
   assign unused_nz = ^status_reg_in[3:2];

   // Out-of-range selects fall back to the register-file operand.
   always_comb begin
      src1 = val_Rn;
      src2 = val_Rm;
      for (int k = 1; k <= NUM_FWD_SRC; k++) begin
         if (int'(fwd_sel_src1) == k) src1 = fwd_values[32*(k-1) +: 32];
         if (int'(fwd_sel_src2) == k) src2 = fwd_values[32*(k-1) +: 32];
      end
   end

   always_comb begin
      val2 = src2;
      if (mem_r_en_in || mem_w_en_in) begin
         val2 = {20'b0, shift_operand};
      end else if (immd) begin
         val2 = ror32({24'b0, shift_operand[7:0]}, {shift_operand[11:8], 1'b0});
      end else begin
         case (shift_operand[6:5])
            2'b00:   val2 = src2 << shift_operand[11:7];
            2'b01:   val2 = src2 >> shift_operand[11:7];
            2'b10:   val2 = 32'($signed(src2) >>> shift_operand[11:7]);
            default: val2 = ror32(src2, shift_operand[11:7]);
         endcase
      end
   end

   // Subtraction is a + ~b + 1, so carry-out is already NOT borrow.
   always_comb begin
      sum     = '0;
      alu_out = '0;
      c_f     = status_reg_in[1];
      v_f     = status_reg_in[0];
      case (exe_cmd)
         CMD_MOV: alu_out = val2;
         CMD_MVN: alu_out = ~val2;
         CMD_AND: alu_out = src1 & val2;
         CMD_ORR: alu_out = src1 | val2;
         CMD_EOR: alu_out = src1 ^ val2;
         CMD_ADD, CMD_ADC: begin
            sum     = {1'b0, src1} + {1'b0, val2}
                    + ((exe_cmd == CMD_ADC) ? 33'(status_reg_in[1]) : 33'd0);
            alu_out = sum[31:0];
            c_f     = sum[32];
            v_f     = (src1[31] == val2[31]) && (sum[31] != src1[31]);
         end
         CMD_SUB, CMD_SBC: begin
            sum     = {1'b0, src1} + {1'b0, ~val2}
                    + ((exe_cmd == CMD_SUB) ? 33'd1 : 33'(status_reg_in[1]));
            alu_out = sum[31:0];
            c_f     = sum[32];
            v_f     = (src1[31] != val2[31]) && (sum[31] != src1[31]);
         end
         default: alu_out = '0;
      endcase
   end

   always_comb begin
      shamt    = 5'(int'(cnt) * MUL_BITS);
      digit    = MUL_BITS'(mul_rm >> shamt);
      partial  = (mul_rn * 32'(digit)) << shamt;
      acc_next = acc + partial;
   end

   assign busy = rst && !flush &&
                 (((state == IDLE) && valid_in && is_mul) || ((state == MUL_RUN) && !last));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state            <= IDLE;
         cnt              <= '0;
         acc              <= '0;
         mul_rn           <= '0;
         mul_rm           <= '0;
         mul_dest         <= '0;
         mul_wb           <= 1'b0;
         mul_sw           <= 1'b0;
         valid_out        <= 1'b0;
         wb_en_out        <= 1'b0;
         mem_r_en_out     <= 1'b0;
         mem_w_en_out     <= 1'b0;
         status_w_en_out  <= 1'b0;
         branch_taken_out <= 1'b0;
         dest_out         <= '0;
         alu_res          <= '0;
         val_Rm_out       <= '0;
         branch_address   <= '0;
         status_out       <= '0;
      end else if (flush) begin
         state            <= IDLE;
         cnt              <= '0;
         acc              <= '0;
         valid_out        <= 1'b0;
         wb_en_out        <= 1'b0;
         mem_r_en_out     <= 1'b0;
         mem_w_en_out     <= 1'b0;
         status_w_en_out  <= 1'b0;
         branch_taken_out <= 1'b0;
      end else if (!stall_in) begin
         case (state)
            IDLE: begin
               if (valid_in && is_mul) begin
                  state            <= MUL_RUN;
                  cnt              <= '0;
                  acc              <= '0;
                  mul_rn           <= src1;
                  mul_rm           <= src2;
                  mul_dest         <= dest_in;
                  mul_wb           <= wb_en_in;
                  mul_sw           <= status_w_en_in;
                  valid_out        <= 1'b0;
                  wb_en_out        <= 1'b0;
                  mem_r_en_out     <= 1'b0;
                  mem_w_en_out     <= 1'b0;
                  status_w_en_out  <= 1'b0;
                  branch_taken_out <= 1'b0;
               end else begin
                  valid_out        <= valid_in;
                  wb_en_out        <= valid_in && wb_en_in;
                  mem_r_en_out     <= valid_in && mem_r_en_in;
                  mem_w_en_out     <= valid_in && mem_w_en_in;
                  status_w_en_out  <= valid_in && status_w_en_in;
                  branch_taken_out <= valid_in && branch_taken_in;
                  dest_out         <= dest_in;
                  alu_res          <= alu_out;
                  val_Rm_out       <= src2;
                  branch_address   <= br_addr;
                  status_out       <= {alu_out[31], (alu_out == 32'd0), c_f, v_f};
               end
            end
            MUL_RUN: begin
               acc <= acc_next;
               if (last) begin
                  state            <= IDLE;
                  cnt              <= '0;
                  valid_out        <= 1'b1;
                  wb_en_out        <= mul_wb;
                  mem_r_en_out     <= 1'b0;
                  mem_w_en_out     <= 1'b0;
                  status_w_en_out  <= mul_sw;
                  branch_taken_out <= 1'b0;
                  dest_out         <= mul_dest;
                  alu_res          <= acc_next;
                  val_Rm_out       <= mul_rm;
                  branch_address   <= '0;
                  status_out       <= {acc_next[31], (acc_next == 32'd0), status_reg_in[1:0]};
               end else begin
                  cnt              <= cnt + CNT_W'(1);
                  valid_out        <= 1'b0;
                  wb_en_out        <= 1'b0;
                  mem_r_en_out     <= 1'b0;
                  mem_w_en_out     <= 1'b0;
                  status_w_en_out  <= 1'b0;
                  branch_taken_out <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_exe_stage_mc.sv
`default_nettype none
// ============================================================================
// tb_exe_stage_mc : directed scoreboard bench; one instance with MUL_BITS=1
//                   and one with MUL_BITS=4 sharing the same stimulus.
// Rev 1.0
// ============================================================================
module tb_exe_stage_mc;
   localparam int NF = 2;
   localparam int SW = $clog2(NF + 1);

   localparam logic [3:0] MOV = 4'b0001, ADD = 4'b0010, ADC = 4'b0011,
                          SUB = 4'b0100, MUL = 4'b1010;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          stall_in, flush, valid_in, wb_en_in, mem_r_en_in, mem_w_en_in;
   logic          status_w_en_in, branch_taken_in, immd;
   logic [3:0]    exe_cmd, dest_in, status_reg_in;
   logic [31:0]   pc_in, val_Rn, val_Rm;
   logic [23:0]   signed_immd_24;
   logic [11:0]   shift_operand;
   logic [SW-1:0] fwd_sel_src1, fwd_sel_src2;
   logic [32*NF-1:0] fwd_values;

   logic        busy, valid_out, wb_en_out, mem_r_en_out, mem_w_en_out;
   logic        status_w_en_out, branch_taken_out;
   logic [3:0]  dest_out, status_out;
   logic [31:0] alu_res, val_Rm_out, branch_address;

   logic        busy_4, valid_out_4, wb_en_out_4, mem_r_en_out_4, mem_w_en_out_4;
   logic        status_w_en_out_4, branch_taken_out_4;
   logic [3:0]  dest_out_4, status_out_4;
   logic [31:0] alu_res_4, val_Rm_out_4, branch_address_4;

   exe_stage_mc #(.NUM_FWD_SRC(NF), .MUL_BITS(1)) dut (
      .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush), .valid_in(valid_in),
      .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
      .status_w_en_in(status_w_en_in), .branch_taken_in(branch_taken_in), .immd(immd),
      .exe_cmd(exe_cmd), .pc_in(pc_in), .val_Rn(val_Rn), .val_Rm(val_Rm), .dest_in(dest_in),
      .signed_immd_24(signed_immd_24), .shift_operand(shift_operand),
      .status_reg_in(status_reg_in), .fwd_sel_src1(fwd_sel_src1), .fwd_sel_src2(fwd_sel_src2),
      .fwd_values(fwd_values), .busy(busy), .valid_out(valid_out), .wb_en_out(wb_en_out),
      .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
      .status_w_en_out(status_w_en_out), .branch_taken_out(branch_taken_out),
      .dest_out(dest_out), .alu_res(alu_res), .val_Rm_out(val_Rm_out),
      .branch_address(branch_address), .status_out(status_out));

   exe_stage_mc #(.NUM_FWD_SRC(NF), .MUL_BITS(4)) dut_4 (
      .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush), .valid_in(valid_in),
      .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
      .status_w_en_in(status_w_en_in), .branch_taken_in(branch_taken_in), .immd(immd),
      .exe_cmd(exe_cmd), .pc_in(pc_in), .val_Rn(val_Rn), .val_Rm(val_Rm), .dest_in(dest_in),
      .signed_immd_24(signed_immd_24), .shift_operand(shift_operand),
      .status_reg_in(status_reg_in), .fwd_sel_src1(fwd_sel_src1), .fwd_sel_src2(fwd_sel_src2),
      .fwd_values(fwd_values), .busy(busy_4), .valid_out(valid_out_4), .wb_en_out(wb_en_out_4),
      .mem_r_en_out(mem_r_en_out_4), .mem_w_en_out(mem_w_en_out_4),
      .status_w_en_out(status_w_en_out_4), .branch_taken_out(branch_taken_out_4),
      .dest_out(dest_out_4), .alu_res(alu_res_4), .val_Rm_out(val_Rm_out_4),
      .branch_address(branch_address_4), .status_out(status_out_4));

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  st;
      logic [3:0]  dst;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
      end
   endtask

   task automatic push(input logic [31:0] r, input logic [3:0] s, input logic [3:0] d);
      exp_t e;
      e.res = r;
      e.st  = s;
      e.dst = d;
      exp_q.push_back(e);
   endtask

   task automatic pop_cmp(input string tag);
      exp_t e;
      chk({tag, "_sb"}, 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({tag, "_res"}, alu_res, e.res);
         chk({tag, "_status"}, 32'(status_out), 32'(e.st));
         chk({tag, "_dest"}, 32'(dest_out), 32'(e.dst));
      end
   endtask

   task automatic idle_in();
      valid_in = 0; wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
      status_w_en_in = 0; branch_taken_in = 0; immd = 0; exe_cmd = '0;
      pc_in = '0; val_Rn = '0; val_Rm = '0; dest_in = '0; signed_immd_24 = '0;
      shift_operand = '0; status_reg_in = '0; fwd_sel_src1 = '0; fwd_sel_src2 = '0;
      fwd_values = '0; stall_in = 0; flush = 0;
   endtask

   task automatic op(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                     input logic [3:0] d);
      idle_in();
      valid_in = 1; wb_en_in = 1; status_w_en_in = 1;
      exe_cmd = cmd; val_Rn = rn; val_Rm = rm; dest_in = d;
   endtask

   // Waits for valid_out, removing the instruction after its issue edge.
   task automatic wait_result(input string tag, input int maxc, input int explat);
      int lat = 0;
      bit got = 0;
      for (int n = 1; n <= maxc && !got; n++) begin
         @(posedge clk); #1;
         lat = n;
         if (n == 1) valid_in = 0;
         got = valid_out;
      end
      chk({tag, "_valid"}, 32'(got), 32'd1);
      chk({tag, "_lat"}, 32'(lat), 32'(explat));
      if (got) pop_cmp(tag);
   endtask

   initial begin : main
      logic [31:0] mexp;
      int bc1, bc4, re1, re4, vc1;

      // Reset with random inputs on two edges.
      idle_in();
      rst = 0;
      for (int i = 0; i < 2; i++) begin
         {valid_in, wb_en_in, mem_r_en_in, mem_w_en_in, status_w_en_in, branch_taken_in,
          immd, stall_in, flush} = 9'($urandom);
         exe_cmd = 4'($urandom); val_Rn = $urandom; val_Rm = $urandom; pc_in = $urandom;
         fwd_values = {$urandom, $urandom}; fwd_sel_src1 = SW'($urandom);
         @(posedge clk); #1;
         chk("rst_ctrl", 32'({valid_out, wb_en_out, mem_r_en_out, mem_w_en_out,
                              status_w_en_out, branch_taken_out}), 32'd0);
         chk("rst_res", alu_res, 32'd0);
         chk("rst_status", 32'(status_out), 32'd0);
         chk("rst_branch", branch_address, 32'd0);
         chk("rst_busy", 32'({busy, busy_4}), 32'd0);
      end
      idle_in();
      rst = 1;
      op(ADD, 32'd5, 32'd7, 4'd3);
      push(32'd12, 4'b0000, 4'd3);
      wait_result("add_after_rst", 4, 1);

      // Forwarding.
      op(SUB, 32'h55, 32'd3, 4'd4);
      fwd_sel_src1 = 2'd2; fwd_values = {32'h10, 32'hAAAA};
      push(32'hD, 4'b0010, 4'd4);
      wait_result("fwd_slot1", 4, 1);
      op(SUB, 32'h20, 32'd3, 4'd5);
      fwd_sel_src1 = 2'd3; fwd_values = {32'h10, 32'hAAAA};
      push(32'h1D, 4'b0010, 4'd5);
      wait_result("fwd_oob", 4, 1);
      op(ADD, 32'd1, 32'h77, 4'd6);
      fwd_sel_src2 = 2'd1; fwd_values = {32'h0, 32'h100};
      push(32'h101, 4'b0000, 4'd6);
      wait_result("fwd_rm", 4, 1);
      chk("fwd_rm_out", val_Rm_out, 32'h100);

      // Flags and operand-2 forms.
      op(ADD, 32'h7FFFFFFF, 32'd1, 4'd1);
      push(32'h80000000, 4'b1001, 4'd1);
      wait_result("add_ovf", 4, 1);
      op(SUB, 32'd0, 32'd1, 4'd2);
      push(32'hFFFFFFFF, 4'b1000, 4'd2);
      wait_result("sub_borrow", 4, 1);
      op(MOV, 32'd0, 32'd0, 4'd8);
      immd = 1; shift_operand = 12'h4FF; status_reg_in = 4'b0011;
      push(32'hFF000000, 4'b1011, 4'd8);
      wait_result("mov_imm", 4, 1);
      op(MOV, 32'd0, 32'h80000000, 4'd9);
      shift_operand = 12'h240;
      push(32'hF8000000, 4'b1000, 4'd9);
      wait_result("mov_asr", 4, 1);
      op(ADC, 32'd1, 32'd1, 4'd10);
      status_reg_in = 4'b0010;
      push(32'd3, 4'b0000, 4'd10);
      wait_result("adc", 4, 1);
      op(ADD, 32'h1000, 32'hDEAD, 4'd11);
      mem_r_en_in = 1; shift_operand = 12'hABC;
      push(32'h1ABC, 4'b0000, 4'd11);
      wait_result("mem_addr", 4, 1);
      chk("mem_r_en_out", 32'(mem_r_en_out), 32'd1);

      // Multiply on both radices.
      op(MUL, 32'hFFFFFFFF, 32'd3, 4'd7);
      push(32'hFFFFFFFD, 4'b1000, 4'd7);
      #1;
      chk("mul_busy_issue", 32'({busy, busy_4}), 32'b11);
      bc1 = 1; bc4 = 1; re1 = 0; re4 = 0; vc1 = 0;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk); #1;
         if (e == 1) valid_in = 0;
         if (busy) bc1++;
         if (busy_4) bc4++;
         if (valid_out) vc1++;
         if (valid_out && re1 == 0) begin
            re1 = e;
            pop_cmp("mul_r1");
         end
         if (valid_out_4 && re4 == 0) begin
            re4 = e;
            chk("mul_r4_res", alu_res_4, 32'hFFFFFFFD);
            chk("mul_r4_status", 32'(status_out_4), 32'b1000);
         end
      end
      chk("mul_r1_busy_cycles", 32'(bc1), 32'd32);
      chk("mul_r4_busy_cycles", 32'(bc4), 32'd8);
      chk("mul_r1_edge", 32'(re1), 32'd33);
      chk("mul_r4_edge", 32'(re4), 32'd9);
      chk("mul_r1_valid_count", 32'(vc1), 32'd1);

      // Flush at cnt=5.
      op(MUL, 32'd123, 32'd456, 4'd2);
      @(posedge clk); #1;
      valid_in = 0;
      repeat (5) begin
         @(posedge clk); #1;
      end
      flush = 1;
      @(posedge clk); #1;
      flush = 0;
      chk("flush_valid", 32'({valid_out, valid_out_4}), 32'd0);
      chk("flush_busy", 32'({busy, busy_4}), 32'd0);
      op(ADD, 32'd2, 32'd3, 4'd3);
      push(32'd5, 4'b0000, 4'd3);
      wait_result("post_flush_add", 4, 1);

      // Stall three edges mid-multiply.
      mexp = 32'h12345 * 32'h789;
      op(MUL, 32'h12345, 32'h789, 4'd12);
      push(mexp, {mexp[31], mexp == 32'd0, 2'b00}, 4'd12);
      re1 = 0; re4 = 0;
      for (int e = 1; e <= 50; e++) begin
         @(posedge clk); #1;
         if (e == 1) valid_in = 0;
         if (e == 6) chk("stall_busy", 32'(busy), 32'd1);
         if (valid_out && re1 == 0) begin
            re1 = e;
            pop_cmp("stall_mul_r1");
         end
         if (valid_out_4 && re4 == 0) begin
            re4 = e;
            chk("stall_mul_r4_res", alu_res_4, mexp);
         end
         stall_in = (e >= 4 && e <= 6);
      end
      chk("stall_mul_r1_edge", 32'(re1), 32'd36);
      chk("stall_mul_r4_edge", 32'(re4), 32'd12);

      // Backward branch.
      op(4'b0000, 32'd0, 32'd0, 4'd13);
      branch_taken_in = 1; pc_in = 32'h100; signed_immd_24 = 24'hFFFFFF;
      push(32'd0, 4'b0100, 4'd13);
      wait_result("branch", 4, 1);
      chk("branch_addr", branch_address, 32'hFC);
      chk("branch_taken", 32'(branch_taken_out), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
